// File: rtl/voice_alloc_pkg.sv
// voice_alloc shared package
// constants, FSM states and the captured event bundle
package voice_alloc_pkg;

  localparam int NUM_VOICES = 16;
  localparam int VIDX_W     = $clog2(NUM_VOICES);
  localparam int ADDR_W     = 6;
  localparam int DATA_W     = 32;
  localparam int AGE_W      = 8;

  localparam logic [ADDR_W-1:0] CAR_BASE = 6'd0;
  localparam logic [ADDR_W-1:0] MOD_BASE = 6'd16;
  localparam logic [ADDR_W-1:0] VEL_BASE = 6'd32;

  typedef enum logic [2:0] {
    IDLE,
    SEARCH,
    WR_CAR,
    WR_MOD,
    WR_VEL
  } voice_alloc_state_t;

  typedef struct packed {
    logic              is_on;
    logic [6:0]        note;
    logic [6:0]        vel;
    logic [DATA_W-1:0] car;
    logic [DATA_W-1:0] mod;
  } ev_t;

endpackage

// File: rtl/voice_alloc_if.sv
// voice_alloc event and register bus bundle
// slave = allocator side, master = driving side
interface voice_alloc_if;
  import voice_alloc_pkg::*;

  logic              ev_valid;
  logic              ev_ready;
  logic              ev_note_on;
  logic [6:0]        ev_note;
  logic [6:0]        ev_vel;
  logic [DATA_W-1:0] ev_car_fcw;
  logic [DATA_W-1:0] ev_mod_fcw;
  logic              reg_wr_en;
  logic [ADDR_W-1:0] reg_wr_addr;
  logic [DATA_W-1:0] reg_wr_data;
  logic              reg_wr_ready;

  modport slave (
    input  ev_valid, ev_note_on, ev_note,
    input  ev_vel, ev_car_fcw, ev_mod_fcw,
    output ev_ready,
    output reg_wr_en, reg_wr_addr, reg_wr_data,
    input  reg_wr_ready
  );

  modport master (
    output ev_valid, ev_note_on, ev_note,
    output ev_vel, ev_car_fcw, ev_mod_fcw,
    input  ev_ready,
    input  reg_wr_en, reg_wr_addr, reg_wr_data,
    output reg_wr_ready
  );

endinterface

// File: rtl/voice_alloc_pick.sv
// voice_pick: combinational voice search
// note match, lowest free voice, oldest voice
module voice_pick
  import voice_alloc_pkg::*;
(
  input  logic [NUM_VOICES-1:0]            active,
  input  logic [NUM_VOICES-1:0][6:0]       notes,
  input  logic [NUM_VOICES-1:0][AGE_W-1:0] ages,
  input  logic [6:0]                       note,
  output logic                             match_hit,
  output logic [VIDX_W-1:0]                match_idx,
  output logic                             free_hit,
  output logic [VIDX_W-1:0]                free_idx,
  output logic [VIDX_W-1:0]                oldest_idx
);

  logic [AGE_W-1:0] best_age;

  // downward scan so the lowest index wins
  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    free_hit  = 1'b0;
    free_idx  = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (active[i] && notes[i] == note) begin
        match_hit = 1'b1;
        match_idx = VIDX_W'(i);
      end
      if (!active[i]) begin
        free_hit = 1'b1;
        free_idx = VIDX_W'(i);
      end
    end
  end

  // strict compare keeps ties on the lowest index
  always_comb begin
    best_age   = ages[0];
    oldest_idx = '0;
    for (int i = 1; i < NUM_VOICES; i++) begin
      if (ages[i] > best_age) begin
        best_age   = ages[i];
        oldest_idx = VIDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/voice_alloc.sv
// voice_alloc: 16-voice allocator and register sequencer
// VOICE_STEAL_EN: steal oldest voice instead of dropping
module voice_alloc
  import voice_alloc_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  voice_alloc_if.slave          bus,
  output logic [NUM_VOICES-1:0] voice_active,
  output logic [7:0]            drop_cnt
);

  voice_alloc_state_t state_q, state_d;
  ev_t                ev_q, ev_d;
  logic [VIDX_W-1:0]  voice_q, voice_d;
  logic [NUM_VOICES-1:0] active_q, active_d;
  logic [NUM_VOICES-1:0][6:0] notes_q, notes_d;
  logic [NUM_VOICES-1:0][AGE_W-1:0] ages_q, ages_d;
  logic [7:0]         drop_q, drop_d;

  logic              ev_rdy;
  logic              accept;
  logic              match_hit, free_hit, alloc_ok;
  logic [VIDX_W-1:0] match_idx, free_idx, oldest_idx;
  logic [VIDX_W-1:0] alloc_idx;

  assign accept       = bus.ev_valid && ev_rdy;
  assign voice_active = active_q;
  assign drop_cnt     = drop_q;

  voice_pick u_pick (
    .active     (active_q),
    .notes      (notes_q),
    .ages       (ages_q),
    .note       (ev_q.note),
    .match_hit  (match_hit),
    .match_idx  (match_idx),
    .free_hit   (free_hit),
    .free_idx   (free_idx),
    .oldest_idx (oldest_idx)
  );

`ifdef VOICE_STEAL_EN
  assign alloc_ok = 1'b1;
`else
  assign alloc_ok = match_hit | free_hit;
`endif

  assign alloc_idx = match_hit ? match_idx :
                     free_hit  ? free_idx  :
                                 oldest_idx;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (accept) state_d = SEARCH;
      SEARCH: begin
        if (ev_q.is_on)
          state_d = alloc_ok ? WR_CAR : IDLE;
        else
          state_d = match_hit ? WR_VEL : IDLE;
      end
      WR_CAR: if (bus.reg_wr_ready) state_d = WR_MOD;
      WR_MOD: if (bus.reg_wr_ready) state_d = WR_VEL;
      WR_VEL: if (bus.reg_wr_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // outputs decoded from the current state
  always_comb begin
    ev_rdy          = rst_n && (state_q == IDLE);
    bus.ev_ready    = ev_rdy;
    bus.reg_wr_en   = 1'b0;
    bus.reg_wr_addr = '0;
    bus.reg_wr_data = '0;
    unique case (state_q)
      WR_CAR: begin
        bus.reg_wr_en   = 1'b1;
        bus.reg_wr_addr = CAR_BASE + ADDR_W'(voice_q);
        bus.reg_wr_data = ev_q.car;
      end
      WR_MOD: begin
        bus.reg_wr_en   = 1'b1;
        bus.reg_wr_addr = MOD_BASE + ADDR_W'(voice_q);
        bus.reg_wr_data = ev_q.mod;
      end
      WR_VEL: begin
        bus.reg_wr_en   = 1'b1;
        bus.reg_wr_addr = VEL_BASE + ADDR_W'(voice_q);
        bus.reg_wr_data = ev_q.is_on ?
                          DATA_W'(ev_q.vel) : '0;
      end
      default: ;
    endcase
  end

  // capture events and update the voice table in SEARCH
  always_comb begin
    ev_d     = ev_q;
    voice_d  = voice_q;
    active_d = active_q;
    notes_d  = notes_q;
    ages_d   = ages_q;
    drop_d   = drop_q;
    if (accept) begin
      ev_d.is_on = bus.ev_note_on && (bus.ev_vel != 7'd0);
      ev_d.note  = bus.ev_note;
      ev_d.vel   = bus.ev_vel;
      ev_d.car   = bus.ev_car_fcw;
      ev_d.mod   = bus.ev_mod_fcw;
    end
    if (state_q == SEARCH) begin
      if (ev_q.is_on) begin
        if (alloc_ok) begin
          voice_d = alloc_idx;
          for (int i = 0; i < NUM_VOICES; i++) begin
            if (active_q[i] && VIDX_W'(i) != alloc_idx &&
                ages_q[i] != '1)
              ages_d[i] = ages_q[i] + 1'b1;
          end
          ages_d[alloc_idx]   = '0;
          notes_d[alloc_idx]  = ev_q.note;
          active_d[alloc_idx] = 1'b1;
        end else if (drop_q != 8'hFF) begin
          drop_d = drop_q + 8'd1;
        end
      end else if (match_hit) begin
        voice_d             = match_idx;
        active_d[match_idx] = 1'b0;
      end
    end
  end

  // datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ev_q     <= '0;
      voice_q  <= '0;
      active_q <= '0;
      notes_q  <= '0;
      ages_q   <= '0;
      drop_q   <= '0;
    end else begin
      ev_q     <= ev_d;
      voice_q  <= voice_d;
      active_q <= active_d;
      notes_q  <= notes_d;
      ages_q   <= ages_d;
      drop_q   <= drop_d;
    end
  end

endmodule

// File: tb/tb_voice_alloc.sv
// tb_voice_alloc: directed self-checking bench
// timings counted from the accept cycle
module tb_voice_alloc;
  import voice_alloc_pkg::*;

  logic clk;
  logic rst_n;
  logic [NUM_VOICES-1:0] voice_active;
  logic [7:0] drop_cnt;
  int checks;
  int failures;

  voice_alloc_if bus ();

  voice_alloc dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .voice_active (voice_active),
    .drop_cnt     (drop_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic on,
                      input logic [6:0] n,
                      input logic [6:0] v,
                      input logic [31:0] c,
                      input logic [31:0] m);
    int k;
    bus.ev_note_on = on;
    bus.ev_note    = n;
    bus.ev_vel     = v;
    bus.ev_car_fcw = c;
    bus.ev_mod_fcw = m;
    bus.ev_valid   = 1'b1;
    k = 0;
    while (bus.ev_ready !== 1'b1 && k < 50) begin
      step();
      k++;
    end
    chk("accept_wait", 32'(bus.ev_ready), 1);
    step();
    bus.ev_valid = 1'b0;
  endtask

  task automatic wr(input string tag,
                    input logic [31:0] a,
                    input logic [31:0] d);
    chk({tag, "_en"}, 32'(bus.reg_wr_en), 1);
    chk({tag, "_addr"}, 32'(bus.reg_wr_addr), a);
    chk({tag, "_data"}, bus.reg_wr_data, d);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    bus.ev_valid = 1'b0;
    bus.ev_note_on = 1'b0;
    bus.ev_note = '0;
    bus.ev_vel = '0;
    bus.ev_car_fcw = '0;
    bus.ev_mod_fcw = '0;
    bus.reg_wr_ready = 1'b1;
    #1;
    chk("rst_ready", 32'(bus.ev_ready), 0);
    chk("rst_en", 32'(bus.reg_wr_en), 0);
    repeat (3) step();
    rst_n = 1'b1;
    #1;
    chk("post_ready", 32'(bus.ev_ready), 1);
    chk("post_addr", 32'(bus.reg_wr_addr), 0);
    chk("post_data", bus.reg_wr_data, 0);
    chk("post_active", 32'(voice_active), 0);
    chk("post_drop", 32'(drop_cnt), 0);

    // note-on 60
    send(1'b1, 7'd60, 7'd100, 32'h1000, 32'h2000);
    chk("on60_c1_en", 32'(bus.reg_wr_en), 0);
    step();
    wr("on60_car", 0, 32'h1000);
    chk("on60_active", 32'(voice_active), 32'h0001);
    step();
    wr("on60_mod", 16, 32'h2000);
    step();
    wr("on60_vel", 32, 100);
    chk("on60_c4_ready", 32'(bus.ev_ready), 0);
    step();
    chk("on60_c5_ready", 32'(bus.ev_ready), 1);
    chk("on60_c5_en", 32'(bus.reg_wr_en), 0);

    // note-off 60
    send(1'b0, 7'd60, 7'd64, 32'h0, 32'h0);
    chk("off60_c1_en", 32'(bus.reg_wr_en), 0);
    step();
    wr("off60_vel", 32, 0);
    chk("off60_active", 32'(voice_active), 0);
    step();
    chk("off60_c3_ready", 32'(bus.ev_ready), 1);

    // repeat note-off: no match
    send(1'b0, 7'd60, 7'd0, 32'h0, 32'h0);
    chk("rep_c1_en", 32'(bus.reg_wr_en), 0);
    step();
    chk("rep_c2_en", 32'(bus.reg_wr_en), 0);
    chk("rep_c2_ready", 32'(bus.ev_ready), 1);

    // velocity-0 note-on is a note-off
    send(1'b1, 7'd62, 7'd0, 32'h3, 32'h4);
    chk("v0_c1_en", 32'(bus.reg_wr_en), 0);
    step();
    chk("v0_c2_en", 32'(bus.reg_wr_en), 0);
    chk("v0_c2_ready", 32'(bus.ev_ready), 1);
    chk("v0_active", 32'(voice_active), 0);

    // fill all 16 voices
    for (int i = 0; i < 16; i++) begin
      send(1'b1, 7'(64 + i), 7'd10, 32'(i), 32'(i + 256));
      step();
      chk("fill_addr", 32'(bus.reg_wr_addr), 32'(i));
      repeat (3) step();
    end
    chk("fill_active", 32'(voice_active), 32'hFFFF);
    chk("fill_drop", 32'(drop_cnt), 0);

    // 17th note
    send(1'b1, 7'd100, 7'd50, 32'hAAAA, 32'hBBBB);
`ifdef VOICE_STEAL_EN
    step();
    wr("steal_car", 0, 32'hAAAA);
    step();
    wr("steal_mod", 16, 32'hBBBB);
    step();
    wr("steal_vel", 32, 50);
    step();
    chk("steal_ready", 32'(bus.ev_ready), 1);
    chk("steal_drop", 32'(drop_cnt), 0);
`else
    chk("drop_c1_en", 32'(bus.reg_wr_en), 0);
    step();
    chk("drop_c2_en", 32'(bus.reg_wr_en), 0);
    chk("drop_c2_ready", 32'(bus.ev_ready), 1);
    chk("drop_cnt", 32'(drop_cnt), 1);
`endif
    chk("full_active", 32'(voice_active), 32'hFFFF);

    // free voice 1, then reallocate it with a stall
    send(1'b0, 7'd65, 7'd0, 32'h0, 32'h0);
    step();
    wr("off65", 33, 0);
    chk("off65_active", 32'(voice_active), 32'hFFFD);
    step();
    send(1'b1, 7'd65, 7'd77, 32'h1234, 32'h5678);
    step();
    wr("st_car", 1, 32'h1234);
    step();
    bus.reg_wr_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wr("st_hold", 17, 32'h5678);
      step();
    end
    bus.reg_wr_ready = 1'b1;
    wr("st_mod", 17, 32'h5678);
    step();
    wr("st_vel", 33, 77);
    chk("st_c7_ready", 32'(bus.ev_ready), 0);
    step();
    chk("st_c8_ready", 32'(bus.ev_ready), 1);

    // retrigger keeps the same voice
    send(1'b1, 7'd66, 7'd9, 32'h66, 32'h99);
    step();
    wr("retrig_car", 2, 32'h66);
    repeat (3) step();
    chk("retrig_active", 32'(voice_active), 32'hFFFF);

    // reset during WR_MOD
    send(1'b1, 7'd68, 7'd20, 32'h44, 32'h88);
    step();
    step();
    wr("rst_mod", 20, 32'h88);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_en", 32'(bus.reg_wr_en), 0);
    chk("rst_mid_ready", 32'(bus.ev_ready), 0);
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk("rel_active", 32'(voice_active), 0);
    chk("rel_ready", 32'(bus.ev_ready), 1);
    chk("rel_drop", 32'(drop_cnt), 0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rel_no_resume", 32'(bus.reg_wr_en), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
